gf2_basis_ctrl: RTL

- Sequencer for one GF(2) basis-builder datapath (pbasis_builder, 32x32).
- Takes candidate rows from a host valid/ready stream and presents them to the builder one per cycle.
- Tracks rank from the builder's accept flag. Once full rank is reached, streams out 64 readback words: 32 basis rows, then 32 inverse rows.
- Sits between the MIPS_GF2 coprocessor register interface and the builder instance.

---
 rtl/gf2_ctrl_pkg.sv | 18 +
 rtl/gf2_basis_ctrl_if.sv | 34 +++
 rtl/gf2_readback_seq.sv | 34 +++
 rtl/gf2_basis_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/gf2_ctrl_pkg.sv
// Shared constants and FSM state encoding for the GF(2) basis-builder sequencer.
// SINGULAR exists only when GF2_CTRL_SINGULAR_EN is defined.
package gf2_ctrl_pkg;
    localparam int GF2_W        = 32;
    localparam int GF2_ROWS     = 32;
    localparam int GF2_RB_WORDS = 64;
    localparam int RIDX_W       = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_READ
`ifdef GF2_CTRL_SINGULAR_EN
        , ST_SINGULAR
`endif
    } gf2_state_t;
endpackage

// File: rtl/gf2_basis_ctrl_if.sv
// Host row stream, builder datapath link and readback stream of gf2_basis_ctrl.
// master = environment (host, builder, sink); slave = controller.
interface gf2_basis_ctrl_if;
    import gf2_ctrl_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [GF2_W-1:0]  in_data;
    logic              in_last;
    logic              bld_clear;
    logic              bld_clk_en;
    logic              bld_write_valid;
    logic [GF2_W-1:0]  bld_cr;
    logic              bld_status;
    logic              bld_read_valid;
    logic [GF2_W-1:0]  bld_out;
    logic              out_valid;
    logic              out_ready;
    logic [GF2_W-1:0]  out_data;
    logic              out_inv;
    logic              out_last;

    modport master (
        output in_valid, in_data, in_last, bld_status, bld_out, out_ready,
        input  in_ready, bld_clear, bld_clk_en, bld_write_valid, bld_cr,
               bld_read_valid, out_valid, out_data, out_inv, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, bld_status, bld_out, out_ready,
        output in_ready, bld_clear, bld_clk_en, bld_write_valid, bld_cr,
               bld_read_valid, out_valid, out_data, out_inv, out_last
    );
endinterface

// File: rtl/gf2_readback_seq.sv
// Readback index and stream flags for the 64-word basis/inverse dump.
// The builder index advances on the same edge as r_ridx, so both stay aligned.
module gf2_readback_seq
    import gf2_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    input  logic i_out_ready,
    output logic o_out_valid,
    output logic o_out_inv,
    output logic o_out_last,
    output logic o_bld_read_valid,
    output logic o_wrap
);
    logic [RIDX_W-1:0] r_ridx;
    logic              w_fire;
    logic              w_at_last;

    assign w_fire           = i_en & i_out_ready;
    assign w_at_last        = (r_ridx == RIDX_W'(GF2_RB_WORDS - 1));
    assign o_out_valid      = i_en;
    assign o_out_inv        = i_en & r_ridx[RIDX_W-1];
    assign o_out_last       = i_en & w_at_last;
    assign o_bld_read_valid = w_fire;
    assign o_wrap           = w_fire & w_at_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_ridx <= '0;
        else if (i_clr)  r_ridx <= '0;
        else if (w_fire) r_ridx <= r_ridx + RIDX_W'(1);
    end
endmodule

// File: rtl/gf2_basis_ctrl.sv
// Sequencer for a 32x32 GF(2) basis builder: load rows to full rank, then stream readback.
// Optional GF2_CTRL_SINGULAR_EN: in_last before full rank parks in SINGULAR.
module gf2_basis_ctrl
    import gf2_ctrl_pkg::*;
#(
    parameter int N_ROWS = GF2_ROWS,
    parameter int REJ_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    gf2_basis_ctrl_if.slave    bus,
    output logic [RIDX_W-1:0]  rank,
    output logic [REJ_W-1:0]   rejects,
    output logic               busy,
    output logic               done,
    output logic               singular
);
    gf2_state_t        r_state, w_state_nxt;
    logic [RIDX_W-1:0] r_rank;
    logic [REJ_W-1:0]  r_rej;
    logic              r_bld_clear;
    logic              r_abort;
    logic              w_load, w_read, w_hs, w_acc, w_rej, w_full_next;
    logic              w_start_ok, w_wrap;

    assign w_load      = (r_state == ST_LOAD);
    assign w_read      = (r_state == ST_READ);
    assign w_hs        = bus.in_valid & bus.in_ready;
    // A zero row never counts toward rank, whatever the builder reports.
    assign w_acc       = w_hs & bus.bld_status & (|bus.in_data);
    assign w_rej       = w_hs & ~w_acc;
    assign w_full_next = (r_rank == RIDX_W'(N_ROWS - 1));

`ifdef GF2_CTRL_SINGULAR_EN
    logic r_singular;
    assign w_start_ok = start & ((r_state == ST_IDLE) | (r_state == ST_SINGULAR));
    assign singular   = r_singular;
`else
    assign w_start_ok = start & (r_state == ST_IDLE);
    assign singular   = 1'b0;
`endif

    assign bus.in_ready        = w_load & ~abort;
    assign bus.bld_write_valid = w_hs;
    assign bus.bld_cr          = w_load ? bus.in_data : '0;
    assign bus.bld_clear       = r_bld_clear;
    assign bus.bld_clk_en      = (r_state != ST_CLEAR);
    assign bus.out_data        = bus.out_valid ? bus.bld_out : '0;
    assign busy                = (r_state != ST_IDLE);
    assign done                = w_wrap;
    assign rank                = r_rank;
    assign rejects             = r_rej;

    gf2_readback_seq u_rb (
        .clk              (clk),
        .reset            (reset),
        .i_en             (w_read & ~abort),
        .i_clr            (r_state == ST_CLEAR),
        .i_out_ready      (bus.out_ready),
        .o_out_valid      (bus.out_valid),
        .o_out_inv        (bus.out_inv),
        .o_out_last       (bus.out_last),
        .o_bld_read_valid (bus.bld_read_valid),
        .o_wrap           (w_wrap)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_CLEAR;
            ST_CLEAR: w_state_nxt = (r_abort || abort) ? ST_IDLE : ST_LOAD;
            ST_LOAD: begin
                if (abort)                    w_state_nxt = ST_CLEAR;
                else if (w_acc && w_full_next) w_state_nxt = ST_READ;
`ifdef GF2_CTRL_SINGULAR_EN
                else if (w_hs && bus.in_last)  w_state_nxt = ST_SINGULAR;
`endif
            end
            ST_READ: begin
                if (abort)       w_state_nxt = ST_CLEAR;
                else if (w_wrap) w_state_nxt = ST_IDLE;
            end
`ifdef GF2_CTRL_SINGULAR_EN
            ST_SINGULAR: if (abort || start) w_state_nxt = ST_CLEAR;
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rank      <= '0;
            r_rej       <= '0;
            r_bld_clear <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bld_clear <= (w_state_nxt == ST_CLEAR);
            // Remembers that this CLEAR came from an abort so it exits to IDLE.
            r_abort     <= (w_state_nxt == ST_CLEAR) && abort && (r_state != ST_IDLE);
            if (w_start_ok) begin
                r_rank <= '0;
                r_rej  <= '0;
            end else begin
                if (w_acc)                r_rank <= r_rank + RIDX_W'(1);
                if (w_rej && r_rej != '1) r_rej  <= r_rej + REJ_W'(1);
            end
        end
    end

`ifdef GF2_CTRL_SINGULAR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                              r_singular <= 1'b0;
        else if (w_start_ok)                                    r_singular <= 1'b0;
        else if (w_load && w_state_nxt == ST_SINGULAR)          r_singular <= 1'b1;
    end
`endif
endmodule
